// File: rtl/req_pkg.sv
// Shared types and defaults for the multi-channel memory request unit.
package req_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    localparam int DEF_NCH     = 2;
    localparam int DEF_TIMEOUT = 255;

    // Channel index width; a single channel still needs one select bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requesting channel strictly after ptr, wrapping.
module rr_arbiter
    import req_pkg::*;
#(
    parameter int N  = DEF_NCH,
    parameter int SW = sel_width(DEF_NCH)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [SW-1:0] grant,
    output logic          valid
);

    logic [SW-1:0] idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = ptr;
        for (int i = 0; i < N; i++) begin
            idx = (idx == SW'(N - 1)) ? '0 : idx + SW'(1);
            if (!valid && req[idx]) begin
                valid = 1'b1;
                grant = idx;
            end
        end
    end

endmodule

// File: rtl/multi_request_unit.sv
// Arbitrates per-channel data read/write requests onto one data port while
// keeping instruction fetch enabled; halt parks everything until reset.
module multi_request_unit
    import req_pkg::*;
#(
    parameter int NCH     = DEF_NCH,
    parameter int TIMEOUT = DEF_TIMEOUT,
    localparam int SEL_W  = sel_width(NCH),
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             halt,
    input  logic             iHit,
    input  logic             dHit,
    input  logic [NCH-1:0]   r_req,
    input  logic [NCH-1:0]   w_req,
    output logic             iRen,
    output logic             dRen,
    output logic             dWen,
    output logic [SEL_W-1:0] dSel,
    output logic [NCH-1:0]   dDone,
    output logic             tout,
    output state_e           dbg_state
);

    state_e           state_q;
    logic [SEL_W-1:0] ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             iRen_q, dRen_q, dWen_q, tout_q;
    logic [SEL_W-1:0] dSel_q;
    logic [NCH-1:0]   dDone_q;

    logic [SEL_W-1:0] arb_grant;
    logic             arb_valid;
    logic             req_held;
    logic             timed_out;
    logic             unused_ihit;

    // iHit is informational only; instruction fetch is never gated by it.
    assign unused_ihit = iHit;

    rr_arbiter #(
        .N  (NCH),
        .SW (SEL_W)
    ) u_arb (
        .req   (r_req | w_req),
        .ptr   (ptr_q),
        .grant (arb_grant),
        .valid (arb_valid)
    );

    // The bit that must stay up is the one matching the granted direction.
    assign req_held  = dWen_q ? w_req[dSel_q] : r_req[dSel_q];
    assign timed_out = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= ST_IDLE;
            ptr_q   <= SEL_W'(NCH - 1);
            cnt_q   <= '0;
            iRen_q  <= 1'b1;
            dRen_q  <= 1'b0;
            dWen_q  <= 1'b0;
            dSel_q  <= '0;
            dDone_q <= '0;
            tout_q  <= 1'b0;
        end else begin
            dDone_q <= '0;
            if (halt) begin
                state_q <= ST_HALTED;
                iRen_q  <= 1'b0;
                dRen_q  <= 1'b0;
                dWen_q  <= 1'b0;
                cnt_q   <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (arb_valid) begin
                            state_q <= ST_GRANT;
                            dSel_q  <= arb_grant;
                            dWen_q  <= w_req[arb_grant];
                            dRen_q  <= ~w_req[arb_grant];
                            cnt_q   <= '0;
                        end
                    end
                    ST_GRANT: begin
                        if (dHit) begin
                            state_q         <= ST_IDLE;
                            dRen_q          <= 1'b0;
                            dWen_q          <= 1'b0;
                            dDone_q[dSel_q] <= 1'b1;
                            ptr_q           <= dSel_q;
                            cnt_q           <= '0;
                        end else if (!req_held) begin
                            // Requester withdrew: abort, keep fairness pointer.
                            state_q <= ST_IDLE;
                            dRen_q  <= 1'b0;
                            dWen_q  <= 1'b0;
                            cnt_q   <= '0;
                        end else if (timed_out) begin
                            state_q <= ST_IDLE;
                            dRen_q  <= 1'b0;
                            dWen_q  <= 1'b0;
                            tout_q  <= 1'b1;
                            ptr_q   <= dSel_q;
                            cnt_q   <= '0;
                        end else if (TIMEOUT != 0) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    ST_HALTED: begin
                        iRen_q <= 1'b0;
                        dRen_q <= 1'b0;
                        dWen_q <= 1'b0;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign iRen      = iRen_q;
    assign dRen      = dRen_q;
    assign dWen      = dWen_q;
    assign dSel      = dSel_q;
    assign dDone     = dDone_q;
    assign tout      = tout_q;
    assign dbg_state = state_q;

endmodule

// File: doc/multi_request_unit.md
MULTI_REQUEST_UNIT -- requirements
Module: multi_request_unit

Interface
REQ-001 Parameter NCH, default 2, number of data request channels (1..8).
REQ-002 Parameter TIMEOUT, default 255, max cycles a data grant waits for dHit; 0 disables the timeout.
REQ-003 CLK  input  1  clock; all state updates on posedge CLK.
REQ-004 nRST  input  1  reset, asynchronous, active-low.
REQ-005 halt  input  1  processor halted; stop all memory requests.
REQ-006 iHit  input  1  instruction access complete (informational; does not gate iRen).
REQ-007 dHit  input  1  data access complete for the current grant.
REQ-008 r_req  input  NCH  per-channel data read request, level, held until served.
REQ-009 w_req  input  NCH  per-channel data write request, level, held until served.
REQ-010 iRen  output  1  instruction read enable.
REQ-011 dRen  output  1  data read enable for the granted channel.
REQ-012 dWen  output  1  data write enable for the granted channel.
REQ-013 dSel  output  max(1,clog2(NCH))  index of the granted channel; valid while dRen|dWen.
REQ-014 dDone  output  NCH  one-cycle pulse on the channel whose access completed.
REQ-015 tout  output  1  sticky flag: a grant timed out.

Function
REQ-016 The FSM SHALL have the states IDLE, GRANT and HALTED; all outputs are registered.
REQ-017 IDLE: if any channel requests, the FSM SHALL choose a channel round-robin, starting after the last-served channel, and enter GRANT; dRen/dWen/dSel SHALL be valid in the cycle after the request is sampled.
REQ-018 A channel with both r_req and w_req set SHALL be granted as a write (dWen=1, dRen=0); its read is served by a later grant.
REQ-019 GRANT: dRen/dWen SHALL be held constant until dHit; on dHit the FSM SHALL return to IDLE with dRen=dWen=0 and dDone[dSel]=1 for exactly one cycle, and the round-robin pointer SHALL advance to dSel.
REQ-020 After every completion there SHALL be one IDLE cycle (bubble) before the next grant.
REQ-021 GRANT: if the granted channel drops its request bit before dHit, the FSM SHALL abort to IDLE without a dDone pulse and SHALL NOT advance the pointer.
REQ-022 A wait counter SHALL count GRANT cycles without dHit; when it reaches TIMEOUT (TIMEOUT>0), the FSM SHALL set tout, abort to IDLE without dDone, and advance the pointer.
REQ-023 dHit in IDLE or HALTED SHALL be ignored.
REQ-024 halt SHALL take priority over every other event: the FSM enters HALTED from any state with iRen=dRen=dWen=0 and no dDone, even if dHit arrives in the same cycle.
REQ-025 HALTED SHALL be left only by reset.
REQ-026 In every state except HALTED, iRen SHALL be 1.

Reset
REQ-027 On nRST low the outputs SHALL be iRen=1, dRen=0, dWen=0, dSel=0, dDone=0 and tout=0, with the state at IDLE, the pointer at NCH-1 and the counter at 0.
REQ-028 Reset asserted mid-grant SHALL drop the grant immediately (asynchronously), with no dDone pulse.

Structure
REQ-029 A shared package req_pkg SHALL hold the state enum and the default NCH and TIMEOUT constants.
REQ-030 The round-robin selection SHALL be a sub-module rr_arbiter (inputs req and ptr; outputs grant index and valid).

Verification (NCH=2, TIMEOUT=4)
REQ-031 Reset, then r_req=01 and dHit after 2 cycles -> dRen=1 and dSel=0 one cycle after the request, dDone=01 for one cycle, then dRen=0.
REQ-032 r_req=11 held, with dHit one cycle after each grant -> grants alternate dSel 0,1,0,1, with a one-cycle IDLE between them.
REQ-033 r_req=01 and w_req=01 together -> first grant has dWen=1 and dRen=0; after dHit the next grant has dRen=1 on channel 0.
REQ-034 w_req=10 and no dHit -> after 4 GRANT cycles tout=1, dWen=0, no dDone; tout stays 1 until reset.
REQ-035 Grant active, and halt and dHit in the same cycle -> next cycle iRen=dRen=dWen=0, dDone=00, and the state stays HALTED despite further requests.
REQ-036 Grant active and nRST pulsed low mid-cycle -> dRen/dWen drop without waiting for a clock edge, iRen=1, tout=0.
